// File: rtl/seq_divider.sv
// seq_divider: 8-bit by 4-bit unsigned restoring divider, one quotient bit
// per clock.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a division with N/D (ignored while busy)
//   N[7:0]       in   dividend, sampled on the accepting edge
//   D[3:0]       in   divisor, sampled on the accepting edge
//   Q[7:0]       out  quotient, held until the next completion
//   R[3:0]       out  remainder, held until the next completion
//   busy         out  division in progress
//   done         out  one-cycle pulse, Q/R/div_by_zero valid
//   div_by_zero  out  result came from D==0 (Q=FF, R=N[3:0])
//
// State   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | iterating (8 steps), or one wait cycle for a zero divisor
// S_DONE  | results just written; done pulse; start may chain here
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] N,
  input  logic [3:0] D,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;   // dividend, shifted out MSB first
  logic [3:0] dvs_q, dvs_d;   // latched divisor
  logic [4:0] rem_q, rem_d;   // partial remainder
  logic [7:0] quo_q, quo_d;   // quotient being assembled
  logic [3:0] cnt_q, cnt_d;   // steps remaining
  logic [7:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       dbz_q, dbz_d;

  logic       accept;
  logic [4:0] rem_sh;
  logic       take;
  logic [4:0] rem_nx;
  logic [7:0] quo_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // One restoring step. The partial remainder is always < divisor <= 15,
  // so after the shift it fits in 5 bits.
  always_comb begin
    rem_sh = {rem_q[3:0], dvd_q[7]};
    take   = (rem_sh >= {1'b0, dvs_q});
    rem_nx = take ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_nx = {quo_q[6:0], take};
  end

  assign accept = start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          dvd_d   = N;
          dvs_d   = D;
          rem_d   = '0;
          quo_d   = '0;
          // A zero divisor spends a single cycle in RUN without stepping,
          // so its done pulse lands one cycle after the accepting edge.
          cnt_d   = (D == 4'd0) ? 4'd1 : 4'd8;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (dvs_q == 4'd0) begin
          q_d     = 8'hFF;
          r_d     = dvd_q[3:0];
          dbz_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          dvd_d = {dvd_q[6:0], 1'b0};
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            q_d     = quo_nx;
            r_d     = rem_nx[3:0];
            dbz_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: table of directed vectors, hand-written
// multi-cycle sequences, and an exhaustive N x D sweep. Expected results are
// queued when a start is accepted and checked when done pulses.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] N;
  logic [3:0] D;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         due;
  } exp_t;

  exp_t sb[$];

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .N           (N),
    .D           (D),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Result checker: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy_done_overlap", int'(busy && done), 0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("Q", int'(Q), int'(e.q));
          chk("R", int'(R), int'(e.r));
          chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
          chk("latency", cyc, e.due);
          if (!e.dbz) begin
            chk("identity", int'(Q) * int'(e.d) + int'(R), int'(e.n));
            chk("r_lt_d", int'(R < e.d), 1);
          end
        end
      end
    end
  end

  // Call away from a rising edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [7:0] n, input logic [3:0] d,
                       input logic [7:0] eq, input logic [3:0] er,
                       input logic edbz);
    exp_t e;
    start = 1'b1;
    N     = n;
    D     = d;
    @(posedge clk);
    #1;
    e.n   = n;
    e.d   = d;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.due = cyc + ((d == 4'd0) ? 1 : 8);
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_Q"}, int'(Q), 0);
    chk({nm, "_R"}, int'(R), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_dbz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0};
    tbl[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
    tbl[2] = '{8'd7,   4'd15, 8'd0,   4'd7, 1'b0};
    tbl[3] = '{8'hA7,  4'd0,  8'hFF,  4'h7, 1'b1};
    tbl[4] = '{8'd6,   4'd3,  8'd2,   4'd0, 1'b0};
    tbl[5] = '{8'd0,   4'd1,  8'd0,   4'd0, 1'b0};
    tbl[6] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
    tbl[7] = '{8'd100, 4'd7,  8'd14,  4'd2, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    N     = '0;
    D     = '0;
    #2;
    chk_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].dbz);
      drain();
    end

    // busy for 8 cycles, previous results held during the run
    issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("run_busy", int'(busy), 1);
      chk("run_done", int'(done), 0);
      chk("hold_Q", int'(Q), 14);
      chk("hold_R", int'(R), 2);
      @(posedge clk);
      #1;
    end
    chk("end_done", int'(done), 1);
    chk("end_busy", int'(busy), 0);
    drain();

    // Back-to-back with start held in the DONE cycle
    issue(8'd50, 4'd5, 8'd10, 4'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_first_done", int'(done), 1);
    issue(8'd15, 4'd4, 8'd3, 4'd3, 1'b0);
    drain();

    // start during RUN ignored; inputs change after the accepting edge
    issue(8'd180, 4'd11, 8'd16, 4'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    N     = 8'd3;
    D     = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    N     = 8'd99;
    D     = 4'd0;
    drain();

    // Reset mid-RUN aborts with no trailing done
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_all_zero("midrun_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_abort_busy", int'(busy), 0);
    chk("post_abort_done", int'(done), 0);

    // First rising edge after reset release accepts start
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd9, 4'd2, 8'd4, 4'd1, 1'b0);
    drain();

    // Exhaustive sweep
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        issue(8'(n), 4'(d), 8'(n / d), 4'(n % d), 1'b0);
        drain();
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
